// File: rtl/mem_access_unit_if.sv
// Request/response handshake and word-memory bus between the MEM stage and mem_access_unit.
// The pipeline/testbench side uses the master modport and the unit uses the slave modport.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_read;
  logic                  mem_write;

  modport master (
    output req_valid, req_write, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport slave (
    input  req_valid, req_write, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store engine over a word-only memory (RMW for sub-word stores); one request in flight,
// req_ready only in IDLE. MEM_MISALIGN_EXC_EN enables immediate error responses for misaligned half/word accesses.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            op_q, op_d;
  logic [31:0]           merged_q, merged_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  misalign;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_val;
  logic [31:0]           merge_val;

`ifdef MEM_MISALIGN_EXC_EN
  logic resp_err_q, resp_err_d;
  assign misalign = ((bus.req_op[1:0] == 2'b01) && bus.req_addr[0]) ||
                    (bus.req_op[1] && (bus.req_addr[1:0] != 2'b00));
  assign bus.resp_err = resp_err_q;
`else
  assign misalign = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  assign bus.req_ready  = (state_q == IDLE) && !reset;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

  // Lane select, extension and merge all work on the word returned for the latched address.
  always_comb begin
    byte_sel  = bus.mem_rdata[7:0];
    half_sel  = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_val  = bus.mem_rdata;
    merge_val = bus.mem_rdata;
    case (addr_q[1:0])
      2'b01:   byte_sel = bus.mem_rdata[15:8];
      2'b10:   byte_sel = bus.mem_rdata[23:16];
      2'b11:   byte_sel = bus.mem_rdata[31:24];
      default: byte_sel = bus.mem_rdata[7:0];
    endcase
    case (op_q[1:0])
      2'b00: begin
        load_val = op_q[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        case (addr_q[1:0])
          2'b01:   merge_val[15:8]  = wdata_q[7:0];
          2'b10:   merge_val[23:16] = wdata_q[7:0];
          2'b11:   merge_val[31:24] = wdata_q[7:0];
          default: merge_val[7:0]   = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        load_val = op_q[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        if (addr_q[1]) merge_val[31:16] = wdata_q[15:0];
        else           merge_val[15:0]  = wdata_q[15:0];
      end
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    case (state_q)
      RD, RD_WAIT, RMW_RD, RMW_WAIT: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      end
      WR: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_wdata = wdata_q;
      end
      RMW_WR: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_wdata = merged_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    merged_d     = merged_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
`ifdef MEM_MISALIGN_EXC_EN
    resp_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          op_d    = bus.req_op;
          if (misalign) begin
            // Rejected without touching memory; the unit never leaves IDLE.
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
`ifdef MEM_MISALIGN_EXC_EN
            resp_err_d   = 1'b1;
`endif
          end else if (!bus.req_write) begin
            state_d = RD;
          end else if (bus.req_op[1]) begin
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_val;
        state_d      = IDLE;
      end
      WR: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
        state_d      = IDLE;
      end
      RMW_RD:  state_d = RMW_WAIT;
      RMW_WAIT: begin
        merged_d = merge_val;
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      op_q         <= 3'b000;
      merged_q     <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
`ifdef MEM_MISALIGN_EXC_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
      merged_q     <= merged_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef MEM_MISALIGN_EXC_EN
      resp_err_q   <= resp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a one-cycle synchronous word memory whose output is gated by MemRead.
// Latency is counted in cycles after the accepting edge: load 3, word store 2, sub-word store 4, misaligned 1.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(32)) ifc ();

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  logic [31:0] mem [0:63];
  logic [31:0] rd_q;

  always @(posedge clk) begin
    if (ifc.mem_write) mem[ifc.mem_addr[7:2]] <= ifc.mem_wdata;
    if (ifc.mem_read)  rd_q <= mem[ifc.mem_addr[7:2]];
  end
  assign ifc.mem_rdata = ifc.mem_read ? rd_q : 32'h0;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int both_cnt = 0;
  int resp_cnt = 0;
  int w0, r0, p0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ifc.mem_write) wr_cnt++;
      if (ifc.mem_read) rd_cnt++;
      if (ifc.mem_read && ifc.mem_write) both_cnt++;
      if (ifc.resp_valid) resp_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns 1 ns after the accepting rising edge.
  task automatic issue(input logic wr, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    ifc.req_write = wr;
    ifc.req_op    = op;
    ifc.req_addr  = addr;
    ifc.req_wdata = wd;
    ifc.req_valid = 1'b1;
    check("req_ready_at_issue", 32'(ifc.req_ready), 32'd1);
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    ifc.req_addr  = 32'hFFFF_FFFF;
    ifc.req_wdata = 32'h0;
    ifc.req_op    = 3'b011;
    ifc.req_write = ~wr;
  endtask

  // Returns at the falling edge of the response cycle.
  task automatic wait_resp(input string tag, input int exp_lat, input logic [31:0] exp_data,
                           input logic exp_err, input logic [31:0] exp_maddr);
    int          lat      = 0;
    int          busy_rdy = 0;
    logic [31:0] a1       = 32'h0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) a1 = ifc.mem_addr;
      if (!ifc.resp_valid && ifc.req_ready) busy_rdy++;
    end while (!ifc.resp_valid && lat < 12);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, ifc.resp_rdata, exp_data);
    check({tag, "_err"}, 32'(ifc.resp_err), 32'(exp_err));
    check({tag, "_ready_busy"}, 32'(busy_rdy), 32'd0);
    check({tag, "_mem_addr"}, a1, exp_maddr);
  endtask

  initial begin
    reset         = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_write = 1'b0;
    ifc.req_op    = 3'b000;
    ifc.req_addr  = 32'h0;
    ifc.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    check("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    check("rst_resp_rdata", ifc.resp_rdata, 32'h0);
    check("rst_resp_err", 32'(ifc.resp_err), 32'd0);
    check("rst_mem_addr", ifc.mem_addr, 32'h0);
    check("rst_mem_strobes", {30'h0, ifc.mem_read, ifc.mem_write}, 32'h0);

    // Word store then word load of the same location.
    w0 = wr_cnt;
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    wait_resp("sw10", 2, 32'h0, 1'b0, 32'h10);
    check("sw10_writes", 32'(wr_cnt - w0), 32'd1);
    check("sw10_mem", mem[4], 32'hDEAD_BEEF);
    @(negedge clk);
    w0 = wr_cnt;
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    wait_resp("lw10", 3, 32'hDEAD_BEEF, 1'b0, 32'h10);
    check("lw10_writes", 32'(wr_cnt - w0), 32'd0);

    // Sub-word loads from 0x8081F2F3.
    issue(1'b1, 3'b011, 32'h10, 32'h8081_F2F3);
    wait_resp("sw10b", 2, 32'h0, 1'b0, 32'h10);
    issue(1'b0, 3'b000, 32'h11, 32'h0);
    wait_resp("lb11", 3, 32'hFFFF_FFF2, 1'b0, 32'h10);
    issue(1'b0, 3'b100, 32'h11, 32'h0);
    wait_resp("lbu11", 3, 32'h0000_00F2, 1'b0, 32'h10);
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    wait_resp("lh12", 3, 32'hFFFF_8081, 1'b0, 32'h10);
    issue(1'b0, 3'b101, 32'h12, 32'h0);
    wait_resp("lhu12", 3, 32'h0000_8081, 1'b0, 32'h10);
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    wait_resp("lb13", 3, 32'hFFFF_FF80, 1'b0, 32'h10);
    issue(1'b0, 3'b111, 32'h10, 32'h0);
    wait_resp("lw10_u", 3, 32'h8081_F2F3, 1'b0, 32'h10);

    // Read-modify-write stores on 0x11223344.
    @(negedge clk);
    issue(1'b1, 3'b010, 32'h20, 32'h1122_3344);
    wait_resp("sw20", 2, 32'h0, 1'b0, 32'h20);
    w0 = wr_cnt;
    issue(1'b1, 3'b000, 32'h22, 32'hFFFF_FFAA);
    wait_resp("sb22", 4, 32'h0, 1'b0, 32'h20);
    check("sb22_writes", 32'(wr_cnt - w0), 32'd1);
    check("sb22_mem", mem[8], 32'h11AA_3344);
    w0 = wr_cnt;
    issue(1'b1, 3'b001, 32'h20, 32'h1234_5566);
    wait_resp("sh20", 4, 32'h0, 1'b0, 32'h20);
    check("sh20_writes", 32'(wr_cnt - w0), 32'd1);
    check("sh20_mem", mem[8], 32'h11AA_5566);

    // Load issued in the response cycle of a store: accepted on that edge.
    @(negedge clk);
    issue(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D);
    wait_resp("sw30", 2, 32'h0, 1'b0, 32'h30);
    check("b2b_resp_valid", 32'(ifc.resp_valid), 32'd1);
    issue(1'b0, 3'b010, 32'h30, 32'h0);
    wait_resp("lw30_b2b", 3, 32'hCAFE_F00D, 1'b0, 32'h30);

    // Reset while a byte store sits in RMW_WAIT.
    @(negedge clk);
    w0 = wr_cnt;
    p0 = resp_cnt;
    issue(1'b1, 3'b000, 32'h20, 32'h0000_0077);
    @(negedge clk);
    @(negedge clk);
    check("rmw_wait_mem_read", 32'(ifc.mem_read), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    check("arst_resp_rdata", ifc.resp_rdata, 32'h0);
    check("arst_resp_err", 32'(ifc.resp_err), 32'd0);
    check("arst_mem_addr", ifc.mem_addr, 32'h0);
    check("arst_mem_wdata", ifc.mem_wdata, 32'h0);
    check("arst_mem_strobes", {30'h0, ifc.mem_read, ifc.mem_write}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_ready_after", 32'(ifc.req_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("arst_no_write", 32'(wr_cnt - w0), 32'd0);
    check("arst_no_resp", 32'(resp_cnt - p0), 32'd0);
    check("arst_mem20", mem[8], 32'h11AA_5566);

`ifdef MEM_MISALIGN_EXC_EN
    w0 = wr_cnt;
    r0 = rd_cnt;
    issue(1'b0, 3'b010, 32'h22, 32'h0);
    wait_resp("lw22_mis", 1, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 3'b001, 32'h21, 32'h0);
    wait_resp("lh21_mis", 1, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 3'b001, 32'h23, 32'h0000_BEEF);
    wait_resp("sh23_mis", 1, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    check("mis_no_read", 32'(rd_cnt - r0), 32'd0);
    check("mis_no_write", 32'(wr_cnt - w0), 32'd0);
    check("mis_mem20", mem[8], 32'h11AA_5566);
    issue(1'b0, 3'b001, 32'h22, 32'h0);
    wait_resp("lh22_ok", 3, 32'h0000_11AA, 1'b0, 32'h20);
`else
    issue(1'b0, 3'b010, 32'h22, 32'h0);
    wait_resp("lw22", 3, 32'h11AA_5566, 1'b0, 32'h20);
    issue(1'b0, 3'b001, 32'h21, 32'h0);
    wait_resp("lh21", 3, 32'h0000_5566, 1'b0, 32'h20);
`endif

    check("no_read_write_overlap", 32'(both_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
